// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one register bank between NUM_REQ cores, one
// single-word read or write per grant, with a lock for exclusive ownership.
module shared_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]    req_wdata,
  input  logic [NUM_REGS*WIDTH-1:0]   reg_q,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REGS-1:0]         reg_wr_en,
  output logic [WIDTH-1:0]            reg_d,
  output logic [WIDTH-1:0]            rdata,
  output logic                        locked,
  output logic [IDX_W-1:0]            owner
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED, LGRANT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_p1;
  logic               lock_p1;

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   win;
  logic [ADDR_W-1:0]  win_addr;
  logic [WIDTH-1:0]   win_wdata;
  logic [WIDTH-1:0]   win_q;

  // First set bit of m at or above p, wrapping from NUM_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] m,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] r;
    logic             found;
    r     = p;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(p) + k) % NUM_REQ);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return IDX_W'((int'(i) + 1) % NUM_REQ);
  endfunction

  // While locked only the owner's request is eligible.
  always_comb begin
    elig = '0;
    if (state == IDLE)
      elig = req;
    else if (state == LOCKED)
      elig = req & (NUM_REQ'(1) << owner);
  end

  assign win       = rr_pick(elig, ptr);
  assign win_addr  = req_addr[win*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[win*WIDTH +: WIDTH];
  assign win_q     = reg_q[win_addr*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      win_p1    <= '0;
      lock_p1   <= 1'b0;
      gnt       <= '0;
      reg_wr_en <= '0;
      reg_d     <= '0;
      rdata     <= '0;
      locked    <= 1'b0;
      owner     <= '0;
    end else begin
      case (state)
        // Arbitration edge: winner's access is registered for the grant cycle
        IDLE, LOCKED: begin
          if (|elig) begin
            state   <= (state == LOCKED) ? LGRANT : GRANT;
            ptr     <= next_idx(win);
            win_p1  <= win;
            lock_p1 <= req_lock[win];
            gnt     <= NUM_REQ'(1) << win;
            if (req_we[win]) begin
              reg_wr_en <= NUM_REGS'(1) << win_addr;
              reg_d     <= win_wdata;
            end else begin
              rdata <= win_q;
            end
          end else if (state == LOCKED && !req_lock[owner]) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        // Grant cycle end: bank captures reg_d; decide whether the lock is held
        GRANT, LGRANT: begin
          gnt       <= '0;
          reg_wr_en <= '0;
          reg_d     <= '0;
          if (lock_p1) begin
            state  <= LOCKED;
            locked <= 1'b1;
            owner  <= win_p1;
          end else begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: vector table of single transactions
// plus hand-written sequences for round-robin, lock and reset corner cases.
module tb_shared_reg_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req, req_we, req_lock;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*WIDTH-1:0]   req_wdata;
  logic [NUM_REGS*WIDTH-1:0]  reg_q;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REGS-1:0]        reg_wr_en;
  logic [WIDTH-1:0]           reg_d, rdata;
  logic                       locked;
  logic [1:0]                 owner;

  logic [WIDTH-1:0] bank [NUM_REGS];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  shared_reg_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .reg_q(reg_q), .gnt(gnt),
    .reg_wr_en(reg_wr_en), .reg_d(reg_d), .rdata(rdata), .locked(locked),
    .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NUM_REGS; i++)
      if (reg_wr_en[i]) bank[i] <= reg_d;
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*WIDTH +: WIDTH] = bank[i];
  end

  typedef struct {
    int          core;
    bit          we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  e_gnt;
    logic [7:0]  e_wr;
    logic [31:0] e_d;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input bit r, input bit we, input bit lk,
                          input logic [2:0] a, input logic [31:0] d);
    req[i]                   = r;
    req_we[i]                = we;
    req_lock[i]              = lk;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*WIDTH +: WIDTH]  = d;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] order [5];
    int last_cyc;
    int n;

    vecs[0] = '{2, 1'b1, 3'd5, 32'hA5A5_0001, 4'b0100, 8'h20, 32'hA5A5_0001, 32'h0};
    vecs[1] = '{2, 1'b0, 3'd5, 32'h0,         4'b0100, 8'h00, 32'h0,         32'hA5A5_0001};
    vecs[2] = '{0, 1'b1, 3'd0, 32'h0000_1234, 4'b0001, 8'h01, 32'h0000_1234, 32'hA5A5_0001};
    vecs[3] = '{3, 1'b1, 3'd7, 32'hFFFF_FFFF, 4'b1000, 8'h80, 32'hFFFF_FFFF, 32'hA5A5_0001};
    vecs[4] = '{3, 1'b0, 3'd7, 32'h0,         4'b1000, 8'h00, 32'h0,         32'hFFFF_FFFF};
    vecs[5] = '{1, 1'b0, 3'd0, 32'h0,         4'b0010, 8'h00, 32'h0,         32'h0000_1234};
    vecs[6] = '{1, 1'b1, 3'd7, 32'hDEAD_BEEF, 4'b0010, 8'h80, 32'hDEAD_BEEF, 32'h0000_1234};
    vecs[7] = '{0, 1'b0, 3'd7, 32'h0,         4'b0001, 8'h00, 32'h0,         32'hDEAD_BEEF};

    for (int i = 0; i < NUM_REGS; i++) bank[i] = '0;
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wr_en", 32'(reg_wr_en), 32'h0);
    chk("rst_reg_d", reg_d, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    reset = 1'b0;

    // Single transactions, including read-after-write to the same address
    for (int v = 0; v < 8; v++) begin
      set_core(vecs[v].core, 1'b1, vecs[v].we, 1'b0, vecs[v].addr, vecs[v].wdata);
      tick();
      chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(vecs[v].e_gnt));
      chk($sformatf("v%0d_wr_en", v), 32'(reg_wr_en), 32'(vecs[v].e_wr));
      chk($sformatf("v%0d_reg_d", v), reg_d, vecs[v].e_d);
      chk($sformatf("v%0d_rdata", v), rdata, vecs[v].e_rdata);
      set_core(vecs[v].core, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      tick();
      chk($sformatf("v%0d_gnt_off", v), 32'(gnt), 32'h0);
      chk($sformatf("v%0d_wr_off", v), 32'(reg_wr_en), 32'h0);
      chk($sformatf("v%0d_d_off", v), reg_d, 32'h0);
    end

    // Four continuous writers: order 0,1,2,3,0 every 2 cycles
    pulse_reset();
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b1, 1'b0, 3'(i), 32'h10 + i);
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (gnt == '0 && n < 10);
      chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(order[k]));
      if (k > 0) chk($sformatf("rr_space%0d", k), cyc - last_cyc, 32'd2);
      last_cyc = cyc;
      for (int j = 0; j < 4; j++) if (gnt[j]) req[j] = 1'b0;
      if (k == 1) set_core(0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h10);
    end
    req = '0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) chk($sformatf("rr_bank%0d", i), bank[i], 32'h10 + i);

    // Lock by core 1 holds off core 3 through a read then a write
    pulse_reset();
    set_core(1, 1'b1, 1'b0, 1'b1, 3'd2, 32'h0);
    set_core(3, 1'b1, 1'b1, 1'b0, 3'd6, 32'h66);
    tick();
    chk("lk_gnt1", 32'(gnt), 32'b0010);
    chk("lk_rdata", rdata, 32'h12);
    chk("lk_wr_rd", 32'(reg_wr_en), 32'h0);
    set_core(1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h77);
    tick();
    chk("lk_locked", 32'(locked), 32'h1);
    chk("lk_owner", 32'(owner), 32'h1);
    chk("lk_gnt_gap", 32'(gnt), 32'h0);
    tick();
    chk("lk_lgnt", 32'(gnt), 32'b0010);
    chk("lk_lwr", 32'(reg_wr_en), 32'h04);
    chk("lk_ld", reg_d, 32'h77);
    chk("lk_locked_lg", 32'(locked), 32'h1);
    set_core(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    chk("lk_unlocked", 32'(locked), 32'h0);
    chk("lk_gnt_idle", 32'(gnt), 32'h0);
    tick();
    chk("lk_gnt3", 32'(gnt), 32'b1000);
    chk("lk_wr3", 32'(reg_wr_en), 32'h40);
    set_core(3, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();

    // Owner drops req and lock: back to IDLE with no grant, core 2 next
    pulse_reset();
    set_core(0, 1'b1, 1'b1, 1'b1, 3'd1, 32'h55);
    set_core(2, 1'b1, 1'b0, 1'b0, 3'd5, 32'h0);
    tick();
    chk("dr_gnt0", 32'(gnt), 32'b0001);
    set_core(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    chk("dr_locked", 32'(locked), 32'h1);
    chk("dr_owner", 32'(owner), 32'h0);
    chk("dr_gnt_l", 32'(gnt), 32'h0);
    tick();
    chk("dr_unlocked", 32'(locked), 32'h0);
    chk("dr_gnt_none", 32'(gnt), 32'h0);
    tick();
    chk("dr_gnt2", 32'(gnt), 32'b0100);
    chk("dr_rdata", rdata, 32'hA5A5_0001);
    set_core(2, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();

    // Reset in a grant cycle clears everything, pointer restarts at 0
    set_core(1, 1'b1, 1'b1, 1'b1, 3'd3, 32'hBAD0_0003);
    tick();
    chk("rs_gnt1", 32'(gnt), 32'b0010);
    reset = 1'b1;
    set_core(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    reset = 1'b0;
    chk("rs_gnt", 32'(gnt), 32'h0);
    chk("rs_wr_en", 32'(reg_wr_en), 32'h0);
    chk("rs_reg_d", reg_d, 32'h0);
    chk("rs_locked", 32'(locked), 32'h0);
    set_core(1, 1'b1, 1'b1, 1'b0, 3'd4, 32'h44);
    set_core(3, 1'b1, 1'b1, 1'b0, 3'd6, 32'h66);
    tick();
    chk("rs_first", 32'(gnt), 32'b0010);
    set_core(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    tick();
    chk("rs_second", 32'(gnt), 32'b1000);
    set_core(3, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();

    // Pointer at 1: core 2 beats core 0 (wrap-around search)
    set_core(0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    chk("wr_setup", 32'(gnt), 32'b0001);
    set_core(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    set_core(0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    set_core(2, 1'b1, 1'b0, 1'b0, 3'd1, 32'h0);
    tick();
    chk("wrap_first", 32'(gnt), 32'b0100);
    set_core(2, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    tick();
    chk("wrap_second", 32'(gnt), 32'b0001);
    set_core(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
